// File: rtl/core_types_pkg.sv
// Shared core-wide sizing defaults for the checkpoint allocator.
package core_types_pkg;
   localparam int unsigned DEF_CHECKPOINT_COUNT       = 8;
   localparam int unsigned DEF_CHECKPOINT_INDEX_WIDTH = 3;
   localparam int unsigned DEF_CHECKPOINT_THRESHOLD   = 3;
endpackage

// File: rtl/checkpoint_range_check.sv
// Combinational test: does idx fall inside the live window [head, head+used) modulo 2**IDX_W.
module checkpoint_range_check #(
   parameter int unsigned IDX_W = 3
) (
   input  logic [IDX_W-1:0] i_idx,
   input  logic [IDX_W-1:0] i_head,
   input  logic [IDX_W:0]   i_used,
   output logic             o_in_range
);
   logic [IDX_W-1:0] w_offset;

   // Distance from the oldest slot; an empty window (used == 0) never matches.
   assign w_offset   = i_idx - i_head;
   assign o_in_range = ({1'b0, w_offset} < i_used);
endmodule

// File: rtl/checkpoint_alloc_ctrl.sv
// Circular checkpoint slot allocator: in-order save/clear with mispredict rollback.
module checkpoint_alloc_ctrl
   import core_types_pkg::*;
#(
   parameter int unsigned CHECKPOINT_COUNT       = DEF_CHECKPOINT_COUNT,
   parameter int unsigned CHECKPOINT_INDEX_WIDTH = DEF_CHECKPOINT_INDEX_WIDTH,
   parameter int unsigned CHECKPOINT_THRESHOLD   = DEF_CHECKPOINT_THRESHOLD
) (
   input  logic                              CLK,
   input  logic                              nRST,
   input  logic                              save_valid,
   output logic                              save_ready,
   output logic [CHECKPOINT_INDEX_WIDTH-1:0] save_index,
   input  logic                              restore_valid,
   input  logic [CHECKPOINT_INDEX_WIDTH-1:0] restore_index,
   input  logic                              clear_valid,
   input  logic [CHECKPOINT_INDEX_WIDTH-1:0] clear_index,
   output logic [CHECKPOINT_INDEX_WIDTH:0]   free_count,
   output logic                              above_threshold,
   output logic                              error_pulse
);
   localparam int unsigned IW = CHECKPOINT_INDEX_WIDTH;
   localparam int unsigned UW = CHECKPOINT_INDEX_WIDTH + 1;

   logic [IW-1:0] r_head;
   logic [IW-1:0] r_tail;
   logic [UW-1:0] r_used;
   logic          r_error;

   logic          w_clear_ok;
   logic [IW-1:0] w_head_clr;
   logic [UW-1:0] w_used_clr;
   logic          w_in_range;
   logic          w_restore_ok;
   logic          w_save_acc;
   logic [IW-1:0] w_restore_off;

   // Clear is resolved first; the restore is judged against the post-clear window.
   assign w_clear_ok = clear_valid && (r_used != '0) && (clear_index == r_head);
   assign w_head_clr = w_clear_ok ? r_head + IW'(1) : r_head;
   assign w_used_clr = w_clear_ok ? r_used - UW'(1) : r_used;

   checkpoint_range_check #(
      .IDX_W (IW)
   ) u_range_check (
      .i_idx      (restore_index),
      .i_head     (w_head_clr),
      .i_used     (w_used_clr),
      .o_in_range (w_in_range)
   );

   assign w_restore_ok  = restore_valid && w_in_range;
   assign w_restore_off = restore_index - w_head_clr;

   // A same-cycle legal clear frees a slot, so a full buffer can still take the save.
   assign save_ready = !restore_valid &&
                       ((r_used < UW'(CHECKPOINT_COUNT)) || w_clear_ok);
   assign w_save_acc = save_valid && save_ready;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_used  <= '0;
         r_error <= 1'b0;
      end else begin
         r_head  <= w_head_clr;
         r_error <= (clear_valid && !w_clear_ok) || (restore_valid && !w_restore_ok);
         if (w_restore_ok) begin
            r_tail <= restore_index;
            r_used <= {1'b0, w_restore_off};
         end else begin
            if (w_save_acc) r_tail <= r_tail + IW'(1);
            r_used <= w_used_clr + UW'(w_save_acc);
         end
      end
   end

   assign save_index      = r_tail;
   assign free_count      = UW'(CHECKPOINT_COUNT) - r_used;
   assign above_threshold = (free_count >= UW'(CHECKPOINT_THRESHOLD));
   assign error_pulse     = r_error;
endmodule

// File: tb/tb_checkpoint_alloc_ctrl.sv
// Self-checking bench for checkpoint_alloc_ctrl against a queue-of-live-slots model.
module tb_checkpoint_alloc_ctrl;
   localparam int N  = 8;
   localparam int TH = 3;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       save_valid = 1'b0;
   logic       save_ready;
   logic [2:0] save_index;
   logic       restore_valid = 1'b0;
   logic [2:0] restore_index = '0;
   logic       clear_valid = 1'b0;
   logic [2:0] clear_index = '0;
   logic [3:0] free_count;
   logic       above_threshold;
   logic       error_pulse;

   checkpoint_alloc_ctrl dut (
      .CLK             (CLK),
      .nRST            (nRST),
      .save_valid      (save_valid),
      .save_ready      (save_ready),
      .save_index      (save_index),
      .restore_valid   (restore_valid),
      .restore_index   (restore_index),
      .clear_valid     (clear_valid),
      .clear_index     (clear_index),
      .free_count      (free_count),
      .above_threshold (above_threshold),
      .error_pulse     (error_pulse)
   );

   always #5 CLK = ~CLK;

   // Model: live slots oldest-first, next slot to hand out, pending error flag.
   int q[$];
   int m_tail;
   bit m_err;
   int n_pass;
   int n_total;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      q.delete();
      m_tail = 0;
      m_err  = 1'b0;
   endtask

   task automatic step(input bit sv, input bit rv, input int ri, input bit cv, input int ci,
                       input string tag);
      bit clr_ok;
      bit rst_ok;
      bit exp_ready;
      int pos;
      save_valid    = sv;
      restore_valid = rv;
      restore_index = 3'(ri);
      clear_valid   = cv;
      clear_index   = 3'(ci);
      #1;
      clr_ok    = cv && (q.size() > 0) && (q[0] == ci);
      exp_ready = !rv && ((q.size() < N) || clr_ok);
      check({tag, " save_index"}, 32'(save_index), 32'(m_tail));
      check({tag, " save_ready"}, 32'(save_ready), 32'(exp_ready));
      check({tag, " free_count"}, 32'(free_count), 32'(N - q.size()));
      check({tag, " above_thr"}, 32'(above_threshold), 32'((N - q.size()) >= TH));
      check({tag, " error_pulse"}, 32'(error_pulse), 32'(m_err));
      @(posedge CLK);
      if (clr_ok) void'(q.pop_front());
      rst_ok = 1'b0;
      if (rv) begin
         pos = -1;
         foreach (q[k]) if (q[k] == ri && pos < 0) pos = k;
         if (pos >= 0) begin
            rst_ok = 1'b1;
            while (q.size() > pos) void'(q.pop_back());
            m_tail = ri;
         end
      end
      if (sv && exp_ready) begin
         q.push_back(m_tail);
         m_tail = (m_tail + 1) % N;
      end
      m_err = (cv && !clr_ok) || (rv && !rst_ok);
      @(negedge CLK);
   endtask

   task automatic idle();
      save_valid = 1'b0; restore_valid = 1'b0; clear_valid = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      idle();
      #2 nRST = 1'b0;
      #1;
      check({tag, " rst free"}, 32'(free_count), 32'(N));
      check({tag, " rst index"}, 32'(save_index), 32'(0));
      check({tag, " rst ready"}, 32'(save_ready), 32'(1));
      check({tag, " rst above"}, 32'(above_threshold), 32'(1));
      check({tag, " rst err"}, 32'(error_pulse), 32'(0));
      restore_valid = 1'b1;
      #1;
      check({tag, " rst ready_rv"}, 32'(save_ready), 32'(0));
      restore_valid = 1'b0;
      model_reset();
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      int ci;
      int ri;
      n_pass  = 0;
      n_total = 0;
      model_reset();
      @(negedge CLK);
      do_reset("init");

      // Eight back-to-back saves, then a ninth that must stall.
      for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, "fill");
      check("full free", 32'(free_count), 32'(0));
      check("full above", 32'(above_threshold), 32'(0));
      step(1, 0, 0, 0, 0, "save_on_full");

      // Full buffer: clear of slot 0 plus save both apply.
      step(1, 0, 0, 1, 0, "full_clr_save");
      check("fcs free", 32'(free_count), 32'(0));
      check("fcs index", 32'(save_index), 32'(1));

      // Reach head 6 / tail 3 / used 5, then roll back to slot 1 with a blocked save.
      for (int i = 1; i < 6; i++) step(0, 0, 0, 1, i, "drain");
      step(1, 0, 0, 0, 0, "wrap_save");
      step(1, 0, 0, 0, 0, "wrap_save");
      check("wrap free", 32'(free_count), 32'(3));
      step(1, 1, 1, 0, 0, "wrap_restore");
      check("wr free", 32'(free_count), 32'(5));
      check("wr index", 32'(save_index), 32'(1));

      // Clear head 2 and restore to 3 in one cycle.
      do_reset("r2");
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, "fill5");
      step(0, 0, 0, 1, 0, "clr0");
      step(0, 0, 0, 1, 1, "clr1");
      step(0, 1, 3, 1, 2, "clr_rest");
      check("cr free", 32'(free_count), 32'(8));
      check("cr index", 32'(save_index), 32'(3));
      check("cr err", 32'(error_pulse), 32'(0));

      // Illegal clear on empty, then out-of-window restore.
      do_reset("r3");
      step(0, 0, 0, 1, 0, "bad_clear");
      check("bc err", 32'(error_pulse), 32'(1));
      step(1, 0, 0, 0, 0, "s0");
      step(1, 0, 0, 0, 0, "s1");
      step(0, 1, 5, 0, 0, "bad_restore");
      check("br err", 32'(error_pulse), 32'(1));
      check("br free", 32'(free_count), 32'(6));
      step(0, 0, 0, 0, 0, "err_clears");
      check("ec err", 32'(error_pulse), 32'(0));
      // Clear and restore aimed at the same head slot: only the clear applies.
      step(0, 1, 0, 1, 0, "clr_rest_head");
      check("crh err", 32'(error_pulse), 32'(1));
      check("crh free", 32'(free_count), 32'(7));

      // Asynchronous reset mid-stream with six live slots.
      do_reset("r4");
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, "fill6");
      check("six free", 32'(free_count), 32'(2));
      do_reset("async");
      step(1, 0, 0, 0, 0, "post_rst_save");
      check("prs index", 32'(save_index), 32'(1));

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         ci = (q.size() > 0 && $urandom_range(3) != 0) ? q[0] : int'($urandom_range(N - 1));
         ri = (q.size() > 0 && $urandom_range(2) != 0) ?
              q[$urandom_range(q.size() - 1)] : int'($urandom_range(N - 1));
         step($urandom_range(2) != 0, $urandom_range(5) == 0, ri,
              $urandom_range(2) == 0, ci, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/checkpoint_alloc_ctrl.md
CHECKPOINT_ALLOC_CTRL -- requirements
Module: checkpoint_alloc_ctrl

Interface
REQ-001 SHALL take parameter CHECKPOINT_COUNT, default 8: number of checkpoint slots; power of two.
REQ-002 SHALL take parameter CHECKPOINT_INDEX_WIDTH, default 3: width of a slot index, log2(CHECKPOINT_COUNT).
REQ-003 SHALL take parameter CHECKPOINT_THRESHOLD, default 3: minimum free slots for above_threshold.
REQ-004 SHALL have one clock; reset is asynchronous and active-low. Ports: CLK input 1 (clock); nRST input 1 (reset).
REQ-005 SHALL have save_valid input 1: request to allocate a checkpoint this cycle.
REQ-006 SHALL have save_ready output 1: an allocation is accepted this cycle.
REQ-007 SHALL have save_index output CHECKPOINT_INDEX_WIDTH: slot granted to the save.
REQ-008 SHALL have restore_valid input 1: mispredict rollback to restore_index.
REQ-009 SHALL have restore_index input CHECKPOINT_INDEX_WIDTH: slot being restored.
REQ-010 SHALL have clear_valid input 1: oldest checkpoint retired.
REQ-011 SHALL have clear_index input CHECKPOINT_INDEX_WIDTH: slot being retired.
REQ-012 SHALL have free_count output CHECKPOINT_INDEX_WIDTH+1: number of free slots.
REQ-013 SHALL have above_threshold output 1: free_count >= CHECKPOINT_THRESHOLD.
REQ-014 SHALL have error_pulse output 1: illegal clear or restore seen last cycle.

Function
REQ-015 SHALL keep registered head (oldest live slot), tail (next slot to allocate) and used count (0..CHECKPOINT_COUNT). Pointers wrap modulo CHECKPOINT_COUNT.
REQ-016 save_index SHALL equal tail combinationally.
REQ-017 save_ready SHALL be 1 when used < CHECKPOINT_COUNT and restore_valid = 0.
REQ-018 Clear and restore SHALL always be accepted and need no ready signal.
REQ-019 An accepted save (save_valid & save_ready) SHALL increment tail and used at the next edge.
REQ-020 A legal clear SHALL increment head and decrement used at the next edge.
  - Legal means used > 0 and clear_index == head.
REQ-021 A legal restore SHALL free restore_index and every younger slot.
  - Legal means used > 0 and restore_index lies in [head, tail) modulo CHECKPOINT_COUNT.
  - Next tail = restore_index.
  - Next used = (restore_index - head) mod CHECKPOINT_COUNT.
REQ-022 Restore SHALL take priority over save in the same cycle; the save is not accepted.
REQ-023 Clear and restore in the same cycle SHALL apply the clear first, then the restore.
  - If restore_index == head, the restore is illegal after the clear, so only the clear applies and error_pulse is set.
REQ-024 Clear and save in the same cycle SHALL both apply; used is unchanged, head and tail both advance.
REQ-025 Save accepted at used == CHECKPOINT_COUNT-1 SHALL make used == CHECKPOINT_COUNT (full) and drop save_ready next cycle.
  - Full and empty are distinguished by used, not by head == tail.
REQ-026 An illegal clear or restore SHALL be ignored (no state change) and SHALL set error_pulse high for exactly the next cycle.
REQ-027 free_count SHALL equal CHECKPOINT_COUNT - used, decoded from the registered used count.
REQ-028 above_threshold SHALL be decoded from free_count. Both update one cycle after the causing event.

Reset
REQ-029 While nRST = 0, head = 0, tail = 0, used = 0 and error_pulse = 0.
  - Resulting outputs: save_index = 0, free_count = CHECKPOINT_COUNT, above_threshold = 1, save_ready = !restore_valid.
REQ-030 Reset asserted mid-operation SHALL discard all live checkpoints immediately and asynchronously.
REQ-031 The first accepted save after nRST deasserts SHALL return index 0.

Structure
REQ-032 CHECKPOINT_COUNT, CHECKPOINT_INDEX_WIDTH and CHECKPOINT_THRESHOLD defaults SHALL come from core_types_pkg.
REQ-033 No new typedefs are required.
REQ-034 One sub-module is natural: checkpoint_range_check, a combinational modulo in-range test of an index against [head, tail) given used.
REQ-035 All state SHALL be flops in this module; there are no memories.

Verification
REQ-036 Reset, then 8 back-to-back saves -> save_index 0..7 in order.
  - free_count 8→0.
  - above_threshold drops when free_count reaches 2.
  - save_ready = 0 on the 9th cycle.
REQ-037 Full (head 0, tail 0, used 8), clear_index 0 with save_valid -> save accepted at index 0, head = 1, used stays 8.
REQ-038 Head 6, tail 3 (used 5, wrapped), restore_index 1 -> tail = 1, used = 3, free_count = 5 next cycle.
  - A same-cycle save_valid is not accepted.
REQ-039 Head 2, used 3, clear_index 2 and restore_index 3 in the same cycle -> head = 3, tail = 3, used = 0, no error.
REQ-040 Empty, clear_valid with clear_index 0 -> state unchanged, error_pulse high for one cycle.
  - Then restore_index 5 with head 0, tail 2 -> ignored, error_pulse pulses again.
REQ-041 nRST asserted with used = 6 mid-stream -> outputs return to reset values without a clock edge.
  - The next save returns index 0.
